// File: rtl/adpcm_a_bus_pkg.sv
// adpcm_a_bus_pkg
// Definitions shared by the ADPCM-A bus emulator and the ADPCM-A memory
// reader: the PCM mux select codes, the emulator FSM state encoding and
// the width of the emulator's phase/timeout counter.
package adpcm_a_bus_pkg;

    // Address nibble selects presented by the reader on mux_sel.
    localparam logic [2:0] MUX_SEL_RAD3_0   = 3'b000;
    localparam logic [2:0] MUX_SEL_RAD7_4   = 3'b100;
    localparam logic [2:0] MUX_SEL_RA9_8    = 3'b101;
    localparam logic [2:0] MUX_SEL_RA23_20  = 3'b001;

    // PCM write-back selects. The reader holds MUX_SEL_PCM_LE_HI while it
    // drives the first (low) PCM nibble onto the YM I/O bus.
    localparam logic [2:0] MUX_SEL_PCM_LE_HI = 3'b011;
    localparam logic [2:0] MUX_SEL_PCM_LE_LO = 3'b010;

    // Wide enough for the largest legal TIMEOUT_CYCLES (1023) and
    // PHASE_CYCLES (255).
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ADDR_LO      = 2'd1,
        ST_ADDR_HI_WAIT = 2'd2
    } bus_state_t;

endpackage

// File: rtl/adpcm_a_nibble_mux.sv
// adpcm_a_nibble_mux
// Emulates the external PCM mux that feeds address nibbles back to the
// reader. The nibble is chosen from the latched transaction address by the
// reader's select and the current RMPX phase, and is registered so it
// appears one cycle after the select changes.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset
//   addr       latched 24-bit transaction address
//   phase      current RMPX level (1 = low address half, 0 = high half)
//   mux_sel    nibble select from the reader
//   mux_oe_n   mux output enable, active-low
//   nibble_out registered emulated mux output
module adpcm_a_nibble_mux
    import adpcm_a_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] addr,
    input  logic        phase,
    input  logic [2:0]  mux_sel,
    input  logic        mux_oe_n,
    output logic [3:0]  nibble_out
);

    logic [3:0] nibble_next;

    // While RMPX is high the RAD/RA pins carry address bits 9..0; after the
    // fall they carry bits 19..10. RA23_20 is not multiplexed by phase.
    always_comb begin
        nibble_next = 4'h0;
        if (!mux_oe_n) begin
            case (mux_sel)
                MUX_SEL_RAD3_0:  nibble_next = phase ? addr[3:0] : addr[13:10];
                MUX_SEL_RAD7_4:  nibble_next = phase ? addr[7:4] : addr[17:14];
                MUX_SEL_RA9_8:   nibble_next = phase ? {2'b00, addr[9:8]}
                                                     : {2'b00, addr[19:18]};
                MUX_SEL_RA23_20: nibble_next = addr[23:20];
                default:         nibble_next = 4'h0;
            endcase
        end
    end

    // One register stage models the mux propagation seen by the reader.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nibble_out <= 4'h0;
        end else begin
            nibble_out <= nibble_next;
        end
    end

endmodule

// File: rtl/adpcm_a_bus_emulator.sv
// adpcm_a_bus_emulator
// Stands in for the YM2610 on the ADPCM-A ROM bus in the loopback self-test.
// A start request latches a byte address, drives RMPX high for the
// address-low phase, drops it, and then waits for the reader to write the
// two PCM nibbles back on the YM I/O bus. The captured byte is presented on
// data_out with a one-cycle data_valid pulse, or error pulses if the high
// nibble never arrives.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   start       request one byte fetch (ignored while busy)
//   addr        byte address, latched on an accepted start
//   busy        high while a transaction is in flight
//   data_out    last captured PCM byte
//   data_valid  one-cycle pulse when data_out updates
//   error       one-cycle pulse on a missing high nibble
//   rmpx        RMPX level seen by the reader
//   mux_sel     PCM mux select from the reader
//   mux_oe_n    PCM mux output enable, active-low
//   nibble_out  emulated PCM mux output to the reader
//   ym_io_in    nibble driven by the reader on the YM I/O bus
//   ym_io_en    reader is driving the YM I/O bus
//   pcm_load    reader's strobe accompanying the high nibble
module adpcm_a_bus_emulator
    import adpcm_a_bus_pkg::*;
#(
    parameter int PHASE_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] addr,
    output logic        busy,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        error,
    output logic        rmpx,
    input  logic [2:0]  mux_sel,
    input  logic        mux_oe_n,
    output logic [3:0]  nibble_out,
    input  logic [3:0]  ym_io_in,
    input  logic        ym_io_en,
    input  logic        pcm_load
);

    localparam logic [CNT_W-1:0] PHASE_LAST   = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bus_state_t       state;
    logic [CNT_W-1:0] count;
    logic [23:0]      addr_q;
    logic [3:0]       low_nibble;

    // Transaction sequencer. All outputs are registered; busy is updated on
    // the same edges that leave or enter IDLE so it always equals
    // (state != IDLE). Capturing the high nibble takes priority over the
    // timeout if both land on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            addr_q     <= '0;
            low_nibble <= 4'h0;
            busy       <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            error      <= 1'b0;
            rmpx       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            error      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q <= addr;
                        rmpx   <= 1'b1;
                        busy   <= 1'b1;
                        count  <= '0;
                        state  <= ST_ADDR_LO;
                    end
                end
                ST_ADDR_LO: begin
                    if (count == PHASE_LAST) begin
                        rmpx  <= 1'b0;
                        count <= '0;
                        state <= ST_ADDR_HI_WAIT;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_ADDR_HI_WAIT: begin
                    if (ym_io_en && pcm_load) begin
                        data_out   <= {ym_io_in, low_nibble};
                        data_valid <= 1'b1;
                        busy       <= 1'b0;
                        count      <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        // A repeated low-nibble write simply replaces the
                        // earlier one, which covers a reader that restarts.
                        if (ym_io_en && (mux_sel == MUX_SEL_PCM_LE_HI)) begin
                            low_nibble <= ym_io_in;
                        end
                        if (count == TIMEOUT_LAST) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            count <= '0;
                            state <= ST_IDLE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    rmpx  <= 1'b0;
                    busy  <= 1'b0;
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    adpcm_a_nibble_mux u_nibble_mux (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr_q),
        .phase      (rmpx),
        .mux_sel    (mux_sel),
        .mux_oe_n   (mux_oe_n),
        .nibble_out (nibble_out)
    );

endmodule

// File: tb/tb_adpcm_a_bus_emulator.sv
// tb_adpcm_a_bus_emulator
// Self-checking bench for adpcm_a_bus_emulator. A behavioural model of the
// ROM bus (address halves by RMPX phase, last-written low nibble, expected
// captured byte) supplies every expected value; randomized addresses,
// selects and nibble traffic drive the checks.
module tb_adpcm_a_bus_emulator;
    import adpcm_a_bus_pkg::*;

    localparam int PHASE = 16;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] addr;
    logic        busy;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        error;
    logic        rmpx;
    logic [2:0]  mux_sel;
    logic        mux_oe_n;
    logic [3:0]  nibble_out;
    logic [3:0]  ym_io_in;
    logic        ym_io_en;
    logic        pcm_load;

    int tests_run    = 0;
    int tests_failed = 0;
    int dv_count     = 0;
    int err_count    = 0;

    // Model of the byte the emulator should currently be presenting.
    logic [7:0] model_data = 8'h00;

    always #5 clk = ~clk;

    adpcm_a_bus_emulator #(
        .PHASE_CYCLES   (PHASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .addr       (addr),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .error      (error),
        .rmpx       (rmpx),
        .mux_sel    (mux_sel),
        .mux_oe_n   (mux_oe_n),
        .nibble_out (nibble_out),
        .ym_io_in   (ym_io_in),
        .ym_io_en   (ym_io_en),
        .pcm_load   (pcm_load)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_count++;
        if (error === 1'b1) err_count++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected mux output: RMPX high exposes address bits 0..9, RMPX low
    // exposes bits 10..19; the top nibble is always bits 20..23.
    function automatic logic [3:0] model_nibble(input logic [23:0] a, input logic phase,
                                                input logic [2:0] sel, input logic oe_n);
        int av;
        int base;
        av   = int'(a);
        base = phase ? 0 : 10;
        if (oe_n) return 4'h0;
        case (sel)
            3'b000:  return 4'((av >> base) % 16);
            3'b100:  return 4'((av >> (base + 4)) % 16);
            3'b101:  return 4'((av >> (base + 8)) % 4);
            3'b001:  return 4'((av >> 20) % 16);
            default: return 4'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start    = 1'b0;
        mux_sel  = 3'b000;
        mux_oe_n = 1'b1;
        ym_io_in = 4'h0;
        ym_io_en = 1'b0;
        pcm_load = 1'b0;
    endtask

    // Leaves the bench in cycle 1 of the transaction (rmpx should be high).
    task automatic begin_txn(input logic [23:0] a);
        addr  = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        addr  = 24'h0;
        idle_inputs();
        tick();
        tick();
        tests_run++; if (rmpx !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rmpx: got %b want 0", rmpx); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (data_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_data_out: got %h want 00", data_out); end
        tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_data_valid: got %b want 0", data_valid); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_error: got %b want 0", error); end
        tests_run++; if (nibble_out !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_nibble: got %h want 0", nibble_out); end
        reset = 1'b1;
        model_data = 8'h00;
        tick();
    endtask

    task automatic test_mux_directed();
        logic [2:0] sels [4];
        logic [3:0] lo_exp [3];
        logic [3:0] hi_exp [4];
        sels   = '{3'b000, 3'b100, 3'b101, 3'b001};
        lo_exp = '{4'h6, 4'h5, 4'h0};
        hi_exp = '{4'hD, 4'h8, 4'h0, 4'h1};
        begin_txn(24'h12_3456);
        tests_run++; if (rmpx !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL dir_start: rmpx %b busy %b want 1 1", rmpx, busy); end
        mux_oe_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mux_sel = sels[i];
            tick();
            tests_run++; if (nibble_out !== lo_exp[i]) begin tests_failed++; $display("[TB] FAIL dir_lo_sel%b: got %h want %h", sels[i], nibble_out, lo_exp[i]); end
        end
        repeat (PHASE - 3) tick();
        tests_run++; if (rmpx !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL dir_fall: rmpx %b busy %b want 0 1", rmpx, busy); end
        for (int i = 0; i < 4; i++) begin
            mux_sel = sels[i];
            tick();
            tests_run++; if (nibble_out !== hi_exp[i]) begin tests_failed++; $display("[TB] FAIL dir_hi_sel%b: got %h want %h", sels[i], nibble_out, hi_exp[i]); end
        end
        mux_oe_n = 1'b1;
        ym_io_en = 1'b1; mux_sel = MUX_SEL_PCM_LE_HI; ym_io_in = 4'h2;
        tick();
        mux_sel = 3'b000; pcm_load = 1'b1; ym_io_in = 4'hB;
        tick();
        idle_inputs();
        model_data = 8'hB2;
        tests_run++; if (data_valid !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL dir_capture: dv %b busy %b want 1 0", data_valid, busy); end
        tests_run++; if (data_out !== model_data) begin tests_failed++; $display("[TB] FAIL dir_data: got %h want %h", data_out, model_data); end
        tick();
        tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL dir_dv_single: got %b want 0", data_valid); end
    endtask

    task automatic test_mux_random(input int n);
        logic [23:0] a;
        logic        ph;
        logic [2:0]  sel;
        logic        oe;
        logic [3:0]  exp_n;
        logic [3:0]  lo, hi;
        for (int t = 0; t < n; t++) begin
            a = 24'($urandom());
            begin_txn(a);
            for (int c = 1; c <= PHASE + 12; c++) begin
                ph = (c <= PHASE);
                tests_run++; if (rmpx !== ph) begin tests_failed++; $display("[TB] FAIL rnd_rmpx c%0d: got %b want %b", c, rmpx, ph); end
                sel = 3'($urandom_range(0, 7));
                oe  = ($urandom_range(0, 3) == 0);
                mux_sel  = sel;
                mux_oe_n = oe;
                exp_n = model_nibble(a, ph, sel, oe);
                tick();
                tests_run++; if (nibble_out !== exp_n) begin tests_failed++; $display("[TB] FAIL rnd_nibble a=%h sel=%b oe_n=%b ph=%b: got %h want %h", a, sel, oe, ph, nibble_out, exp_n); end
            end
            lo = 4'($urandom()); hi = 4'($urandom());
            mux_oe_n = 1'b1;
            ym_io_en = 1'b1; mux_sel = MUX_SEL_PCM_LE_HI; ym_io_in = lo;
            tick();
            mux_sel = 3'b000; pcm_load = 1'b1; ym_io_in = hi;
            tick();
            idle_inputs();
            model_data = {hi, lo};
            tests_run++; if (data_valid !== 1'b1 || data_out !== model_data) begin tests_failed++; $display("[TB] FAIL rnd_capture: dv %b data %h want 1 %h", data_valid, data_out, model_data); end
            tick();
        end
    endtask

    task automatic test_timeout();
        int e0;
        int d0;
        e0 = err_count;
        d0 = dv_count;
        begin_txn(24'($urandom()));
        repeat (PHASE) tick();
        tests_run++; if (rmpx !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL tmo_fall: rmpx %b busy %b want 0 1", rmpx, busy); end
        for (int k = 1; k <= TMO + 2; k++) begin
            tick();
            tests_run++; if (error !== (k == TMO)) begin tests_failed++; $display("[TB] FAIL tmo_error k=%0d: got %b want %b", k, error, (k == TMO)); end
            if (k == TMO) begin
                tests_run++; if (busy !== 1'b0 || data_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_state: busy %b dv %b want 0 0", busy, data_valid); end
                tests_run++; if (data_out !== model_data) begin tests_failed++; $display("[TB] FAIL tmo_data: got %h want %h", data_out, model_data); end
            end
        end
        tests_run++; if (err_count - e0 !== 1 || dv_count !== d0) begin tests_failed++; $display("[TB] FAIL tmo_pulses: errors %0d valids %0d want 1 0", err_count - e0, dv_count - d0); end
    endtask

    task automatic test_reset_mid();
        int e0;
        int d0;
        begin_txn(24'($urandom()));
        repeat (3) tick();
        e0 = err_count;
        d0 = dv_count;
        reset = 1'b0;
        tick();
        tests_run++; if (rmpx !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_state: rmpx %b busy %b want 0 0", rmpx, busy); end
        tests_run++; if (data_valid !== 1'b0 || error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_pulse: dv %b err %b want 0 0", data_valid, error); end
        reset = 1'b1;
        model_data = 8'h00;
        repeat (PHASE + TMO + 5) tick();
        tests_run++; if (dv_count !== d0 || err_count !== e0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_after: valids %0d errors %0d busy %b want 0 0 0", dv_count - d0, err_count - e0, busy); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] addrs [3];
        logic [3:0]  lo, hi;
        int d0;
        int e0;
        addrs = '{24'h000000, 24'hFFFFFF, 24'h000400};
        d0 = dv_count;
        e0 = err_count;
        addr  = addrs[0];
        start = 1'b1;
        tick();
        for (int t = 0; t < 3; t++) begin
            tests_run++; if (busy !== 1'b1 || rmpx !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_start%0d: busy %b rmpx %b want 1 1", t, busy, rmpx); end
            if (t == 2) start = 1'b0;
            repeat (PHASE) tick();
            tests_run++; if (rmpx !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_fall%0d: got %b want 0", t, rmpx); end
            if (t == 2) start = 1'b1;
            mux_oe_n = 1'b0; mux_sel = 3'b000;
            tick();
            start = (t < 2);
            tests_run++; if (nibble_out !== model_nibble(addrs[t], 1'b0, 3'b000, 1'b0)) begin tests_failed++; $display("[TB] FAIL b2b_rad%0d: got %h want %h", t, nibble_out, model_nibble(addrs[t], 1'b0, 3'b000, 1'b0)); end
            mux_sel = 3'b001;
            tick();
            tests_run++; if (nibble_out !== model_nibble(addrs[t], 1'b0, 3'b001, 1'b0)) begin tests_failed++; $display("[TB] FAIL b2b_ra23_%0d: got %h want %h", t, nibble_out, model_nibble(addrs[t], 1'b0, 3'b001, 1'b0)); end
            mux_oe_n = 1'b1;
            lo = 4'($urandom()); hi = 4'($urandom());
            ym_io_en = 1'b1; mux_sel = MUX_SEL_PCM_LE_HI; ym_io_in = lo;
            tick();
            mux_sel = 3'b000; pcm_load = 1'b1; ym_io_in = hi;
            if (t < 2) addr = addrs[t + 1];
            tick();
            ym_io_en = 1'b0; pcm_load = 1'b0;
            model_data = {hi, lo};
            tests_run++; if (data_valid !== 1'b1 || busy !== 1'b0 || data_out !== model_data) begin tests_failed++; $display("[TB] FAIL b2b_capture%0d: dv %b busy %b data %h want 1 0 %h", t, data_valid, busy, data_out, model_data); end
            tick();
        end
        idle_inputs();
        tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle: busy %b want 0", busy); end
        tests_run++; if (dv_count - d0 !== 3 || err_count !== e0) begin tests_failed++; $display("[TB] FAIL b2b_pulses: valids %0d errors %0d want 3 0", dv_count - d0, err_count - e0); end
    endtask

    task automatic test_stray_and_overwrite();
        int d0;
        d0 = dv_count;
        // Low nibble written twice; the second write must win.
        begin_txn(24'($urandom()));
        repeat (PHASE) tick();
        ym_io_en = 1'b1; mux_sel = MUX_SEL_PCM_LE_HI; ym_io_in = 4'h1;
        tick();
        ym_io_in = 4'h7;
        tick();
        ym_io_en = 1'b0; mux_sel = 3'b000;
        repeat (3) tick();
        ym_io_en = 1'b1; pcm_load = 1'b1; ym_io_in = 4'hC;
        tick();
        idle_inputs();
        model_data = 8'hC7;
        tests_run++; if (data_valid !== 1'b1 || data_out !== 8'hC7) begin tests_failed++; $display("[TB] FAIL overwrite: dv %b data %h want 1 c7", data_valid, data_out); end
        tick();
        // Stray writes and pcm_load while IDLE are ignored.
        d0 = dv_count;
        ym_io_en = 1'b1; mux_sel = MUX_SEL_PCM_LE_HI; ym_io_in = 4'h3; pcm_load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (data_valid !== 1'b0 || busy !== 1'b0 || data_out !== model_data) begin tests_failed++; $display("[TB] FAIL stray_idle%0d: dv %b busy %b data %h want 0 0 %h", i, data_valid, busy, data_out, model_data); end
        end
        idle_inputs();
        // Stray low write during ADDR_LO, then only the high nibble: the low
        // nibble must still be the 7 from the previous transaction.
        begin_txn(24'($urandom()));
        ym_io_en = 1'b1; mux_sel = MUX_SEL_PCM_LE_HI; ym_io_in = 4'h3;
        tick();
        idle_inputs();
        repeat (PHASE - 1) tick();
        ym_io_en = 1'b1; pcm_load = 1'b1; ym_io_in = 4'h5;
        tick();
        idle_inputs();
        model_data = 8'h57;
        tests_run++; if (data_valid !== 1'b1 || data_out !== model_data) begin tests_failed++; $display("[TB] FAIL stray_lo: dv %b data %h want 1 %h", data_valid, data_out, model_data); end
        tick();
        tests_run++; if (dv_count - d0 !== 1) begin tests_failed++; $display("[TB] FAIL stray_pulses: valids %0d want 1", dv_count - d0); end
    endtask

    task automatic test_random_txns(input int n);
        logic [3:0] lo, hi;
        int nw;
        for (int t = 0; t < n; t++) begin
            begin_txn(24'($urandom()));
            repeat (PHASE) tick();
            nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++) begin
                lo = 4'($urandom());
                ym_io_en = 1'b1; mux_sel = MUX_SEL_PCM_LE_HI; ym_io_in = lo;
                tick();
                ym_io_en = 1'b0; mux_sel = 3'($urandom_range(0, 7)); ym_io_in = 4'($urandom());
                repeat ($urandom_range(0, 5)) tick();
            end
            repeat ($urandom_range(0, 20)) tick();
            hi = 4'($urandom());
            ym_io_en = 1'b1; pcm_load = 1'b1; mux_sel = 3'b000; ym_io_in = hi;
            tick();
            idle_inputs();
            model_data = {hi, lo};
            tests_run++; if (data_valid !== 1'b1 || data_out !== model_data || error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rtxn%0d: dv %b err %b data %h want 1 0 %h", t, data_valid, error, data_out, model_data); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_mux_directed();
        test_mux_random(4);
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_stray_and_overwrite();
        test_random_txns(6);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
